// File: rtl/bram_stream_reader.sv
// Streams sequential words out of the 1024x16 block RAM onto a valid/ready port.
// Covers the RAM's one-cycle read latency with a 2-entry skid FIFO and an in-flight flag.
module bram_stream_reader #(
  parameter int DW   = 16,
  parameter int WL   = 1024,
  parameter int LENW = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [$clog2(WL)-1:0] base,
  input  logic [LENW-1:0]       len,
  output logic                  busy,
  output logic                  done,
  output logic [12:0]           A,
  output logic                  EN,
  output logic [3:0]            WE,
  output logic [DW-1:0]         Di,
  input  logic [DW-1:0]         Do,
  output logic [DW-1:0]         m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);
  localparam int AW = $clog2(WL);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          r_state, w_next;
  logic [AW-1:0]   r_base;
  logic [LENW-1:0] r_len, r_rd_cnt, r_out_cnt;
  logic [DW-1:0]   r_mem [2];
  logic            r_wptr, r_rptr, r_inflight;
  logic [1:0]      r_count;
  logic [12:0]     r_a;
  logic            r_busy, r_done;

  logic            w_pop, w_issue, w_last_pop;
  logic [AW-1:0]   w_idx;
  logic [12:0]     w_addr;
  logic [LENW-1:0] w_len_m1;

  assign w_len_m1   = r_len - {{(LENW-1){1'b0}}, 1'b1};
  assign m_tvalid   = (r_count != 2'd0);
  assign m_tdata    = r_mem[r_rptr];
  assign m_tlast    = m_tvalid && (r_out_cnt == w_len_m1);
  assign w_pop      = m_tvalid & m_tready;
  assign w_last_pop = w_pop && (r_out_cnt == w_len_m1);

  // Room check counts the word still in flight and credits a same-cycle pop,
  // so the FIFO never needs a third slot.
  assign w_issue = (r_state == RUN) && (r_rd_cnt < r_len) &&
                   (({1'b0, r_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop}));

  assign w_idx  = r_base + r_rd_cnt[AW-1:0];
  assign w_addr = {{(11-AW){1'b0}}, w_idx, 2'b00};
  assign A      = w_issue ? w_addr : r_a;
  assign EN     = r_busy;
  assign WE     = 4'b0;
  assign Di     = '0;
  assign busy   = r_busy;
  assign done   = r_done;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = (len != '0) ? RUN : FIN;
      RUN:  if (w_last_pop) w_next = FIN;
      FIN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_rd_cnt   <= '0;
      r_out_cnt  <= '0;
      r_a        <= '0;
      r_inflight <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_count    <= 2'd0;
      r_mem[0]   <= '0;
      r_mem[1]   <= '0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == RUN);
      r_done     <= (w_next == FIN);
      r_inflight <= w_issue;
      if (r_state == IDLE && start) begin
        r_base    <= base;
        r_len     <= len;
        r_rd_cnt  <= '0;
        r_out_cnt <= '0;
      end else begin
        if (w_issue) r_rd_cnt  <= r_rd_cnt + {{(LENW-1){1'b0}}, 1'b1};
        if (w_pop)   r_out_cnt <= r_out_cnt + {{(LENW-1){1'b0}}, 1'b1};
      end
      if (w_issue) r_a <= w_addr;
      if (r_inflight) begin
        r_mem[r_wptr] <= Do;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: command table plus hand-written
// restart-while-busy and mid-command reset sequences, against a 1-cycle RAM model.
module tb_bram_stream_reader;
  logic        CLK = 1'b0;
  logic        RST, start, m_tready;
  logic [9:0]  base;
  logic [10:0] len;
  logic        busy, done, EN, m_tvalid, m_tlast;
  logic [12:0] A;
  logic [3:0]  WE;
  logic [15:0] Di, Do, m_tdata, ram_q;
  logic [15:0] mem [1024];

  int n_vec = 0;
  int n_err = 0;

  bram_stream_reader dut (
    .CLK(CLK), .RST(RST), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .A(A), .EN(EN), .WE(WE), .Di(Di), .Do(Do),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (EN) ram_q <= mem[A[11:2]];
  assign Do = EN ? ram_q : 16'h0;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    int          mode;     // 0: ready=1, 1: 1,0,0,1,0,1 pattern, 2: irregular
    bit          poke;     // re-assert start while busy
    int          exp_done; // absolute done cycle, 0 = relative to last handshake
    logic [12:0] exp_a0;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0: rdy = 1'b1;
      1: rdy = ((c - 1) % 6 == 0) || ((c - 1) % 6 == 3) || ((c - 1) % 6 == 5);
      default: rdy = ((c * 7) % 3) != 0;
    endcase
  endfunction

  task automatic run_cmd(input vec_t v);
    int beats, done_c, last_hs, c;
    logic prev_stall;
    logic [15:0] prev_data;
    logic prev_last;
    beats = 0; done_c = 0; last_hs = 0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    @(negedge CLK);
    start = 1'b1; base = v.base; len = v.len; m_tready = rdy(v.mode, 1);
    for (c = 1; c <= 100; c++) begin
      @(negedge CLK);
      start = 1'b0;
      if (v.poke && (c == 2 || c == 4)) begin
        start = 1'b1; base = 10'h100; len = 11'd2;
      end
      m_tready = rdy(v.mode, c);
      #1;
      if (c == 1 && v.len != 0) begin
        chk("busy_c1", busy, 1'b1);
        chk("en_c1", EN, 1'b1);
      end
      if (v.len == 0) chk("en_len0", EN, 1'b0);
      if (v.len == 0) chk("tvalid_len0", m_tvalid, 1'b0);
      if (v.mode == 0 && c == 2 && v.len != 0) chk("tvalid_c2", m_tvalid, 1'b0);
      if (v.mode == 0 && c == 3 && v.len != 0) chk("tvalid_c3", m_tvalid, 1'b1);
      if (v.mode == 0 && c <= int'(v.len))
        chk("addr", A, (v.exp_a0 + 13'(4 * (c - 1))) & 13'h0FFF);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1'b1);
        chk("stall_data", m_tdata, prev_data);
        chk("stall_last", m_tlast, prev_last);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      prev_last = m_tlast;
      if (m_tvalid && m_tready) begin
        chk("beat_data", m_tdata, 16'h1000 + 16'((v.base + 10'(beats)) & 10'h3FF));
        chk("beat_last", m_tlast, (beats == int'(v.len) - 1));
        beats++;
        last_hs = c;
      end
      if (done) begin
        done_c = c;
        chk("busy_at_done", busy, 1'b0);
        break;
      end
    end
    if (done_c == 0) chk("done_timeout", 0, 1);
    chk("beat_count", beats, v.len);
    if (v.exp_done != 0) chk("done_cycle", done_c, v.exp_done);
    else chk("done_after_last_hs", done_c, last_hs + 1);
    // a stray start seen while busy must not launch a second command
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", m_tvalid, 1'b0);
      chk("idle_done", done, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_en"}, EN, 1'b0);
    chk({nm, "_a"}, A, 13'h0);
    chk({nm, "_we"}, WE, 4'h0);
    chk({nm, "_di"}, Di, 16'h0);
    chk({nm, "_tvalid"}, m_tvalid, 1'b0);
    chk({nm, "_tlast"}, m_tlast, 1'b0);
    chk({nm, "_tdata"}, m_tdata, 16'h0);
  endtask

  vec_t vecs [7];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
    vecs[0] = '{10'h010, 11'd4, 0, 1'b0, 7,  13'h040};
    vecs[1] = '{10'h010, 11'd4, 1, 1'b0, 0,  13'h040};
    vecs[2] = '{10'd1022, 11'd4, 0, 1'b0, 7, 13'hFF8};
    vecs[3] = '{10'h000, 11'd0, 0, 1'b0, 1,  13'h000};
    vecs[4] = '{10'h010, 11'd4, 0, 1'b1, 7,  13'h040};
    vecs[5] = '{10'h3F0, 11'd8, 0, 1'b0, 11, 13'hFC0};
    vecs[6] = '{10'h200, 11'd6, 2, 1'b0, 0,  13'h800};

    RST = 1'b1; start = 1'b0; base = '0; len = '0; m_tready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_reset_vals("reset");
    RST = 1'b0;

    foreach (vecs[i]) run_cmd(vecs[i]);

    // abort a len=8 command with reset during cycle 3
    @(negedge CLK);
    start = 1'b1; base = 10'h0; len = 11'd8; m_tready = 1'b1;
    @(negedge CLK); start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("abort_c3_valid", m_tvalid, 1'b1);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    chk_reset_vals("abort");
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      #1;
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_valid", m_tvalid, 1'b0);
    end
    run_cmd('{10'h000, 11'd1, 0, 1'b0, 4, 13'h000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side streaming front end for the 1024x16 block RAM. On a start command it issues sequential word reads from a base word index, absorbs the RAM's one-cycle registered-address read latency, and presents the words on a valid/ready output stream with full backpressure support. It sits directly on the RAM's `CLK`/`EN`/`WE`/`A`/`Di`/`Do` port and feeds downstream compute or DMA logic.

## Interface
Parameters:
- `DW`, default 16: data width, matching the RAM word.
- `WL`, default 1024: RAM depth in words; must be a power of 2.
- `LENW`, default 11: width of the length field (`2^(LENW-1) >= WL`).

Ports (clock and reset first):
- `CLK` input, 1 bit: the only clock.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: command strobe, sampled in IDLE only.
- `base` input, log2(WL) bits: first word index.
- `len` input, LENW bits: number of words to read, 0..WL.
- `busy` output, 1 bit: command in progress.
- `done` output, 1 bit: single-cycle pulse at command completion.
- `A` output, 13 bits: RAM byte address, `{0, word_idx, 2'b00}`.
- `EN` output, 1 bit: RAM enable.
- `WE` output, 4 bits: RAM write enables, constant 0.
- `Di` output, DW bits: RAM write data, constant 0.
- `Do` input, DW bits: RAM read data, valid one cycle after `A`. It is gated by the current-cycle `EN`.
- `m_tdata` output, DW bits: stream data.
- `m_tvalid` output, 1 bit: stream valid.
- `m_tready` input, 1 bit: stream ready.
- `m_tlast` output, 1 bit: marks the final beat of the command.

## Operation
- States: IDLE, RUN, FIN.
  - IDLE -> RUN when `start=1` and `len!=0`.
  - IDLE -> FIN when `start=1` and `len=0`.
  - RUN -> FIN on the handshake of the last beat.
  - FIN -> IDLE unconditionally.
- `start` is ignored outside IDLE. `base` and `len` are latched on accept.
- Counters:
  - `rd_cnt` counts reads issued.
  - `out_cnt` counts beats handshaked.
  - Word index = `(base + rd_cnt) mod WL`, so addresses wrap from WL-1 to 0. `A[12]` is always 0.
- Buffer:
  - A 2-entry FIFO holds read data.
  - `inflight` is a 1-bit flag set in the cycle a read is issued.
  - In the following cycle, `Do` is written into the FIFO.
- Issue rule: a read is issued in RUN when `rd_cnt < len` and `count + inflight - pop < 2`, where `pop = m_tvalid & m_tready`. This path is combinational from `m_tready` to `A`.
- When no read is issued, `A` holds its previous value.
- `EN` is high in every RUN cycle, so `Do` is never masked during a capture. `EN` is low in IDLE and FIN.
- Stream:
  - `m_tvalid` = FIFO not empty.
  - `m_tdata` = FIFO head.
  - `m_tlast` = 1 when the head is beat `len-1`.
  - `m_tdata` and `m_tlast` are held stable while `m_tvalid & !m_tready`.
- `busy` = 1 in RUN. `done` = 1 in FIN. Both are registered outputs.
- Width rule: counters are LENW bits. The address sum is log2(WL) bits, and its carry is discarded.

## Timing
- Reset values: `busy=0`, `done=0`, `EN=0`, `A=0`, `WE=0`, `Di=0`, `m_tvalid=0`, `m_tlast=0`, `m_tdata=0`. State resets to IDLE, the FIFO is emptied and `inflight` is cleared.
- Cycle-level sequence for a start sampled at edge 0:
  - Cycle 1: RUN begins, `busy=1`, `EN=1`, `A` carries word 0.
  - Cycle 2: `Do` carries word 0 and is captured at the end of the cycle.
  - Cycle 3: `m_tvalid=1`.
- Start-to-first-beat latency is 3 cycles.
- With `m_tready` held at 1, throughput is 1 beat per cycle, and the last beat of len N appears in cycle N+2.
- `done` pulses in the cycle after the last handshake. `busy` is 0 in that cycle.
- For `len=0`: `done` pulses in cycle 1, and no beats or reads are produced.
- `RST` during RUN aborts the command:
  - All outputs return to their reset values on the next edge.
  - No `done` pulse is produced.
  - Buffered data is discarded.
- Backpressure never drops or duplicates a word. At most 2 words are buffered, plus 0 in flight while full.

## Test plan
- `base=0x010`, `len=4`, `m_tready=1`, RAM[i]=0x1000+i:
  - `A` = 0x040, 0x044, 0x048, 0x04C in cycles 1-4.
  - Beats 0x1010..0x1013 in cycles 3-6, with `m_tlast` on 0x1013.
  - `done` in cycle 7.
- Same command with `m_tready` toggling 1,0,0,1,0,1,...: beats appear in order with no loss, and data is stable while stalled. `done` comes exactly one cycle after the fourth handshake.
- `base=1022`, `len=4`: words 1022, 1023, 0, 1 are read. `A` = 0xFF8, 0xFFC, 0x000, 0x004.
- `len=0`:
  - `done` in cycle 1.
  - `m_tvalid` stays 0.
  - `EN` stays 0.
- `start` re-asserted while `busy`: the in-progress command completes unchanged, and no second command runs.
- `RST` asserted in cycle 3 of a `len=8` command:
  - Next cycle: all outputs are at their reset values and there is no `done`.
  - A subsequent `base=0`, `len=1` command returns RAM[0] normally.
